// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   localparam int unsigned DMEM_ADDR_W = 8;
   localparam int unsigned DWIDTH      = 32;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t ACCESS = 2'd1;
   localparam state_t RESP   = 2'd2;

   typedef struct packed {
      logic              we;
      logic [DWIDTH-1:0] addr;
      logic [DWIDTH-1:0] wdata;
   } dmem_req_t;

   // Any address bit at or above the memory's index width is out of range.
   function automatic logic addr_out_of_range(input logic [DWIDTH-1:0] addr,
                                              input int unsigned        aw);
      return (addr >> aw) != '0;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way arbiter: round-robin on ties, or port 0 first when fixed_pri.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   input  logic       fixed_pri,
   output logic [1:0] gnt
);

   logic w_p0_first;

   assign w_p0_first = fixed_pri | last_gnt;
   assign gnt[0]     = req[0] & (~req[1] | w_p0_first);
   assign gnt[1]     = req[1] & ~gnt[0];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port combinational DMEM between the CPU port (0) and the debug/loader port (1).
// One access per three cycles: latch in IDLE, drive DMEM in ACCESS, acknowledge in RESP.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = DMEM_ADDR_W,
   parameter int unsigned FIXED_PRI = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [DWIDTH-1:0] addr0,
   input  logic [DWIDTH-1:0] addr1,
   input  logic [DWIDTH-1:0] wdata0,
   input  logic [DWIDTH-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DWIDTH-1:0] rdata0,
   output logic [DWIDTH-1:0] rdata1,
   output logic              busy,
   output logic [DWIDTH-1:0] mem_address,
   output logic [DWIDTH-1:0] mem_data_in,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DWIDTH-1:0] mem_data_out
);

   localparam logic L_FIXED = 1'(FIXED_PRI != 0);

   state_t            r_state;
   state_t            w_state_nxt;
   dmem_req_t         w_sel;
   logic [1:0]        w_gnt;
   logic              w_load;
   logic              w_sel_err;
   logic              w_resp0;
   logic              w_resp1;
   logic [DWIDTH-1:0] w_rd_val;

   logic              r_we;
   logic              r_range_err;
   logic              r_win;
   logic              r_last_gnt;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_err0;
   logic              r_err1;
   logic [DWIDTH-1:0] r_rdata0;
   logic [DWIDTH-1:0] r_rdata1;
   logic              r_busy;
   logic [DWIDTH-1:0] r_mem_address;
   logic [DWIDTH-1:0] r_mem_data_in;
   logic              r_mem_write;
   logic              r_mem_read;

   rr_arb2 u_arb (
      .req       ({req1, req0}),
      .last_gnt  (r_last_gnt),
      .fixed_pri (L_FIXED),
      .gnt       (w_gnt)
   );

   always_comb begin
      w_sel = '{we: we0, addr: addr0, wdata: wdata0};
      if (w_gnt[1]) begin
         w_sel = '{we: we1, addr: addr1, wdata: wdata1};
      end
   end

   assign w_sel_err = addr_out_of_range(w_sel.addr, ADDR_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_gnt) begin
               w_load      = 1'b1;
               w_state_nxt = ACCESS;
            end
         end
         ACCESS:  w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_resp0  = (r_state == ACCESS) & ~r_win;
   assign w_resp1  = (r_state == ACCESS) & r_win;
   assign w_rd_val = (~r_we & ~r_range_err) ? mem_data_out : '0;

   // Winner bookkeeping, captured only when a request is accepted in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we        <= 1'b0;
         r_range_err <= 1'b0;
         r_win       <= 1'b0;
         r_last_gnt  <= 1'b1;
      end else if (w_load) begin
         r_we        <= w_sel.we;
         r_range_err <= w_sel_err;
         r_win       <= w_gnt[1];
         r_last_gnt  <= w_gnt[1];
      end
   end

   // DMEM drive registers double as the latched payload; they are nonzero only during ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_address <= '0;
         r_mem_data_in <= '0;
         r_mem_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_busy        <= 1'b0;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_err0        <= 1'b0;
         r_err1        <= 1'b0;
         r_rdata0      <= '0;
         r_rdata1      <= '0;
      end else begin
         r_mem_address <= (w_load & ~w_sel_err) ? w_sel.addr  : '0;
         r_mem_data_in <= (w_load & ~w_sel_err) ? w_sel.wdata : '0;
         r_mem_write   <= w_load & w_sel.we & ~w_sel_err;
         r_mem_read    <= w_load & ~w_sel.we & ~w_sel_err;
         r_busy        <= (w_state_nxt != IDLE);
         r_ack0        <= w_resp0;
         r_ack1        <= w_resp1;
         r_err0        <= w_resp0 & r_range_err;
         r_err1        <= w_resp1 & r_range_err;
         r_rdata0      <= w_resp0 ? w_rd_val : '0;
         r_rdata1      <= w_resp1 ? w_rd_val : '0;
      end
   end

   assign ack0        = r_ack0;
   assign ack1        = r_ack1;
   assign err0        = r_err0;
   assign err1        = r_err1;
   assign rdata0      = r_rdata0;
   assign rdata1      = r_rdata1;
   assign busy        = r_busy;
   assign mem_address = r_mem_address;
   assign mem_data_in = r_mem_data_in;
   assign mem_write   = r_mem_write;
   assign mem_read    = r_mem_read;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin instance (0) and fixed-priority instance (1), each with its own DMEM.
module tb_dmem_arbiter;

   localparam int NCYC = 1000;

   logic clk = 1'b0;
   logic rst_n;
   logic clr_mem;

   logic [1:0]       req0, req1, we0, we1;
   logic [1:0][31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]       ack0, ack1, err0, err1, busy, mw, mr;
   logic [1:0][31:0] rdata0, rdata1, maddr, mdi, mdo;

   logic [31:0] dmem0 [256];
   logic [31:0] dmem1 [256];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      dmem_arbiter #(.ADDR_W(8), .FIXED_PRI(g)) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .req0         (req0[g]),
         .req1         (req1[g]),
         .we0          (we0[g]),
         .we1          (we1[g]),
         .addr0        (addr0[g]),
         .addr1        (addr1[g]),
         .wdata0       (wdata0[g]),
         .wdata1       (wdata1[g]),
         .ack0         (ack0[g]),
         .ack1         (ack1[g]),
         .err0         (err0[g]),
         .err1         (err1[g]),
         .rdata0       (rdata0[g]),
         .rdata1       (rdata1[g]),
         .busy         (busy[g]),
         .mem_address  (maddr[g]),
         .mem_data_in  (mdi[g]),
         .mem_write    (mw[g]),
         .mem_read     (mr[g]),
         .mem_data_out (mdo[g])
      );
   end

   // Combinational-read, clocked-write DMEM models
   assign mdo[0] = dmem0[maddr[0][7:0]];
   assign mdo[1] = dmem1[maddr[1][7:0]];

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 256; i++) begin
            dmem0[i] <= 32'h0;
            dmem1[i] <= 32'h0;
         end
      end else begin
         if (mw[0]) dmem0[maddr[0][7:0]] <= mdi[0];
         if (mw[1]) dmem1[maddr[1][7:0]] <= mdi[1];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int d, input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd);
      if (p == 0) begin
         req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = wd;
      end else begin
         req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = wd;
      end
   endtask

   function automatic logic get_ack(input int d, input int p);
      return (p == 0) ? ack0[d] : ack1[d];
   endfunction

   function automatic logic get_err(input int d, input int p);
      return (p == 0) ? err0[d] : err1[d];
   endfunction

   function automatic logic [31:0] get_rd(input int d, input int p);
      return (p == 0) ? rdata0[d] : rdata1[d];
   endfunction

   task automatic reset_dut(input bit clr);
      rst_n   = 1'b0;
      clr_mem = clr;
      for (int d = 0; d < 2; d++) begin
         set_req(d, 0, 1'b0, 1'b0, 32'h0, 32'h0);
         set_req(d, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      repeat (2) @(negedge clk);
      clr_mem = 1'b0;
      rst_n   = 1'b1;
   endtask

   // Single transaction from an idle arbiter; observes the four cycles after the request is raised.
   task automatic do_txn(input int d, input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic err,
                         output logic [31:0] rd, output int nmw, output int nmr,
                         output logic [2:0] bmask, output logic [31:0] acc_addr,
                         output logic [31:0] acc_wd, output int stray);
      lat = 0; err = 1'b0; rd = 32'h0; nmw = 0; nmr = 0; bmask = 3'b000;
      acc_addr = 32'h0; acc_wd = 32'h0; stray = 0;
      set_req(d, p, 1'b1, we, a, wd);
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (n <= 3) bmask[n-1] = busy[d];
         if (mw[d]) nmw++;
         if (mr[d]) nmr++;
         if (n == 1) begin
            acc_addr = maddr[d];
            acc_wd   = mdi[d];
         end
         if (get_ack(d, 1 - p)) stray++;
         if (get_ack(d, p)) begin
            if (lat == 0) begin
               lat = n;
               err = get_err(d, p);
               rd  = get_rd(d, p);
            end
            set_req(d, p, 1'b0, we, a, wd);
         end
      end
      set_req(d, p, 1'b0, we, a, wd);
   endtask

   // Transaction-level reference: one grant outstanding per instance, described by its grant edge.
   bit          g_valid [2];
   int          g_edge  [2];
   int          g_port  [2];
   logic        g_we    [2];
   logic        g_err   [2];
   logic [31:0] g_addr  [2];
   logic [31:0] g_wdata [2];
   logic [31:0] g_rd    [2];
   int          m_last  [2];
   bit          pend    [2][2];
   logic [31:0] p_addr  [2][2];
   logic        p_we    [2][2];
   logic [31:0] p_wdata [2][2];
   logic [31:0] mm      [2][256];

   task automatic rand_step(input int d, input int e);
      bit          in_acc, in_resp;
      bit          dropped [2];
      logic [6:0]  exp_flags, act_flags;
      logic [31:0] exp_rd0, exp_rd1, exp_ma, exp_md;
      int          w, r;
      logic [31:0] a;

      in_acc  = g_valid[d] && (e == g_edge[d]);
      in_resp = g_valid[d] && (e == g_edge[d] + 1);
      exp_flags = {in_resp && g_port[d] == 0, in_resp && g_port[d] == 1,
                   in_resp && g_port[d] == 0 && g_err[d], in_resp && g_port[d] == 1 && g_err[d],
                   in_acc || in_resp, in_acc && g_we[d] && !g_err[d], in_acc && !g_we[d] && !g_err[d]};
      exp_rd0 = (in_resp && g_port[d] == 0) ? g_rd[d] : 32'h0;
      exp_rd1 = (in_resp && g_port[d] == 1) ? g_rd[d] : 32'h0;
      exp_ma  = (in_acc && !g_err[d]) ? g_addr[d]  : 32'h0;
      exp_md  = (in_acc && !g_err[d]) ? g_wdata[d] : 32'h0;
      act_flags = {ack0[d], ack1[d], err0[d], err1[d], busy[d], mw[d], mr[d]};
      check($sformatf("rand d%0d e%0d ack/err/busy/mem_wr/mem_rd", d, e), 64'(act_flags), 64'(exp_flags));
      check($sformatf("rand d%0d e%0d rdata0:rdata1", d, e), {rdata0[d], rdata1[d]}, {exp_rd0, exp_rd1});
      check($sformatf("rand d%0d e%0d mem_address:mem_data_in", d, e), {maddr[d], mdi[d]}, {exp_ma, exp_md});

      dropped[0] = 1'b0;
      dropped[1] = 1'b0;
      if (in_resp) begin
         pend[d][g_port[d]]    = 1'b0;
         dropped[g_port[d]]    = 1'b1;
         set_req(d, g_port[d], 1'b0, 1'b0, 32'h0, 32'h0);
      end
      for (int p = 0; p < 2; p++) begin
         if (!pend[d][p] && !dropped[p] && $urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom() | 32'h100;
            else if (r == 1) a = 32'hFF;
            else             a = 32'($urandom_range(0, 15));
            pend[d][p]    = 1'b1;
            p_addr[d][p]  = a;
            p_we[d][p]    = 1'($urandom_range(0, 1));
            p_wdata[d][p] = $urandom();
            set_req(d, p, 1'b1, p_we[d][p], a, p_wdata[d][p]);
         end
      end

      // Predict the grant taken at the coming edge
      if ((!g_valid[d] || e + 1 >= g_edge[d] + 3) && (pend[d][0] || pend[d][1])) begin
         if (pend[d][0] && pend[d][1]) w = (d == 1) ? 0 : 1 - m_last[d];
         else                          w = pend[d][0] ? 0 : 1;
         g_valid[d] = 1'b1;
         g_edge[d]  = e + 1;
         g_port[d]  = w;
         g_we[d]    = p_we[d][w];
         g_addr[d]  = p_addr[d][w];
         g_wdata[d] = p_wdata[d][w];
         g_err[d]   = p_addr[d][w] > 32'hFF;
         g_rd[d]    = (!g_we[d] && !g_err[d]) ? mm[d][g_addr[d][7:0]] : 32'h0;
         if (g_we[d] && !g_err[d]) mm[d][g_addr[d][7:0]] = g_wdata[d];
         m_last[d]  = w;
      end
   endtask

   typedef struct {
      int          p;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        tbl [9];
      int          lat, nmw, nmr, stray, a0_first, a0_second, a1, cnt0, cnt1, nack, nbusy;
      logic        err, rr;
      logic [31:0] rd, acc_addr, acc_wd;
      logic [2:0]  bmask;
      string       nm;

      tbl[0] = '{0, 1'b1, 32'h10,        32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1] = '{0, 1'b0, 32'h10,        32'h11111111, 1'b0, 32'hDEADBEEF};
      tbl[2] = '{1, 1'b1, 32'h00,        32'h12345678, 1'b0, 32'h0};
      tbl[3] = '{1, 1'b1, 32'h100,       32'h00000BAD, 1'b1, 32'h0};
      tbl[4] = '{0, 1'b0, 32'h00,        32'h22222222, 1'b0, 32'h12345678};
      tbl[5] = '{1, 1'b1, 32'hFF,        32'hA5A5A5A5, 1'b0, 32'h0};
      tbl[6] = '{1, 1'b0, 32'hFF,        32'h33333333, 1'b0, 32'hA5A5A5A5};
      tbl[7] = '{0, 1'b0, 32'h80000000,  32'h44444444, 1'b1, 32'h0};
      tbl[8] = '{1, 1'b0, 32'h10,        32'h55555555, 1'b0, 32'hDEADBEEF};

      // Reset values, observed while reset is held
      rst_n   = 1'b0;
      clr_mem = 1'b1;
      for (int d = 0; d < 2; d++) begin
         set_req(d, 0, 1'b0, 1'b0, 32'h0, 32'h0);
         set_req(d, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset d%0d flags", d),
               64'({ack0[d], ack1[d], err0[d], err1[d], busy[d], mw[d], mr[d]}), 64'h0);
         check($sformatf("reset d%0d rdata", d), {rdata0[d], rdata1[d]}, 64'h0);
         check($sformatf("reset d%0d mem bus", d), {maddr[d], mdi[d]}, 64'h0);
      end
      clr_mem = 1'b0;
      rst_n   = 1'b1;

      for (int i = 0; i < 9; i++) begin
         do_txn(0, tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                lat, err, rd, nmw, nmr, bmask, acc_addr, acc_wd, stray);
         nm = $sformatf("vec%0d", i);
         check({nm, " ack latency"}, 64'(lat), 64'd2);
         check({nm, " err"}, 64'(err), 64'(tbl[i].exp_err));
         check({nm, " rdata"}, 64'(rd), 64'(tbl[i].exp_rd));
         check({nm, " mem_write pulses"}, 64'(nmw), (tbl[i].we && !tbl[i].exp_err) ? 64'd1 : 64'd0);
         check({nm, " mem_read pulses"}, 64'(nmr), (!tbl[i].we && !tbl[i].exp_err) ? 64'd1 : 64'd0);
         check({nm, " busy cycles"}, 64'(bmask), 64'b011);
         check({nm, " access addr"}, 64'(acc_addr), tbl[i].exp_err ? 64'h0 : 64'(tbl[i].addr));
         check({nm, " access wdata"}, 64'(acc_wd), tbl[i].exp_err ? 64'h0 : 64'(tbl[i].wdata));
         check({nm, " other-port ack"}, 64'(stray), 64'd0);
      end
      check("dmem[0x00] after out-of-range write", 64'(dmem0[8'h00]), 64'h12345678);

      // Tie after reset: port 0 first, port 1 next, re-raised port 0 after that
      reset_dut(1'b0);
      set_req(0, 0, 1'b1, 1'b0, 32'h1, 32'h0);
      set_req(0, 1, 1'b1, 1'b0, 32'h2, 32'h0);
      a0_first = 0; a0_second = 0; a1 = 0; rr = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (ack0[0]) begin
            if (a0_first == 0) a0_first = n;
            else if (a0_second == 0) a0_second = n;
            set_req(0, 0, 1'b0, 1'b0, 32'h1, 32'h0);
         end else if (a0_first != 0 && !rr) begin
            set_req(0, 0, 1'b1, 1'b0, 32'h1, 32'h0);
            rr = 1'b1;
         end
         if (ack1[0]) begin
            if (a1 == 0) a1 = n;
            set_req(0, 1, 1'b0, 1'b0, 32'h2, 32'h0);
         end
      end
      check("tie ack0 cycle", 64'(a0_first), 64'd2);
      check("tie ack1 cycle", 64'(a1), 64'd5);
      check("tie repeat ack0 cycle", 64'(a0_second), 64'd8);

      // Fixed priority: port 1 only after port 0 stops asking
      reset_dut(1'b0);
      set_req(1, 0, 1'b1, 1'b0, 32'h3, 32'h0);
      set_req(1, 1, 1'b1, 1'b0, 32'h4, 32'h0);
      cnt0 = 0; cnt1 = 0; a1 = 0; rr = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rr) begin
            set_req(1, 0, 1'b1, 1'b0, 32'h3, 32'h0);
            rr = 1'b0;
         end
         if (ack0[1]) begin
            cnt0++;
            set_req(1, 0, 1'b0, 1'b0, 32'h3, 32'h0);
            if (cnt0 < 4) rr = 1'b1;
         end
         if (ack1[1]) begin
            cnt1++;
            if (a1 == 0) a1 = n;
            set_req(1, 1, 1'b0, 1'b0, 32'h4, 32'h0);
         end
      end
      check("fixed-pri port0 grants", 64'(cnt0), 64'd4);
      check("fixed-pri port1 grants", 64'(cnt1), 64'd1);
      check("fixed-pri port1 ack cycle", 64'(a1), 64'd14);

      // Reset during ACCESS of a write
      reset_dut(1'b0);
      set_req(0, 0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
      @(negedge clk);
      check("midrst mem_write in ACCESS", 64'(mw[0]), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst mem_write after reset", 64'(mw[0]), 64'd0);
      check("midrst busy after reset", 64'(busy[0]), 64'd0);
      set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      nack = 0; nbusy = 0;
      repeat (4) begin
         @(negedge clk);
         nack  += int'(ack0[0] | ack1[0]);
         nbusy += int'(busy[0]);
      end
      check("midrst acks after release", 64'(nack), 64'd0);
      check("midrst busy after release", 64'(nbusy), 64'd0);
      check("midrst dmem[0x20] untouched", 64'(dmem0[8'h20]), 64'h0);
      do_txn(0, 0, 1'b0, 32'h20, 32'h0, lat, err, rd, nmw, nmr, bmask, acc_addr, acc_wd, stray);
      check("midrst reissued read latency", 64'(lat), 64'd2);
      check("midrst reissued read rdata", 64'(rd), 64'h0);

      // Randomized traffic on both instances against the transaction model
      reset_dut(1'b1);
      for (int d = 0; d < 2; d++) begin
         g_valid[d] = 1'b0;
         g_edge[d]  = 0;
         g_port[d]  = 0;
         g_we[d]    = 1'b0;
         g_err[d]   = 1'b0;
         g_addr[d]  = 32'h0;
         g_wdata[d] = 32'h0;
         g_rd[d]    = 32'h0;
         m_last[d]  = 1;
         pend[d][0] = 1'b0;
         pend[d][1] = 1'b0;
         for (int i = 0; i < 256; i++) mm[d][i] = 32'h0;
      end
      for (int e = 1; e <= NCYC; e++) begin
         @(negedge clk);
         rand_step(0, e);
         rand_step(1, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
